// File: rtl/ntt_addr_gen_pkg.sv
// Shared constants, FSM state type and index-expansion helpers for the
// 512-point NTT bank address generator.
package ntt_addr_gen_pkg;

    localparam int N       = 512;
    localparam int BANKS   = 4;
    localparam int IDX_W   = $clog2(N);
    localparam int BANK_W  = $clog2(BANKS);
    localparam int ADDR_W  = IDX_W - BANK_W;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = ADDR_W;
    localparam int STAGE_W = 4;

    localparam logic [STAGE_W-1:0] LAST_STAGE = 4'd8;
    localparam logic [CNT_W-1:0]   CNT_LAST   = 7'd127;

    localparam logic [SEL_W-1:0] SEL_U0 = 2'b00;
    localparam logic [SEL_W-1:0] SEL_V0 = 2'b01;
    localparam logic [SEL_W-1:0] SEL_U1 = 2'b10;
    localparam logic [SEL_W-1:0] SEL_V1 = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // One read (or write-back) beat: enable plus per-bank address and role.
    typedef struct packed {
        logic                            en;
        logic [BANKS-1:0][ADDR_W-1:0]    addr;
        logic [BANKS-1:0][SEL_W-1:0]     sel;
    } bank_req_t;

    function automatic logic [STAGE_W-1:0] partner_bit(input logic [STAGE_W-1:0] s);
        logic [STAGE_W-1:0] t;
        if (s == LAST_STAGE) begin
            t = 4'd7;
        end else begin
            t = s ^ 4'd1;
        end
        return t;
    endfunction

    // Spread the counter bits LSB-first over every index bit except s and t.
    function automatic logic [IDX_W-1:0] expand_index(input logic [CNT_W-1:0]   c,
                                                      input logic [STAGE_W-1:0] s,
                                                      input logic [STAGE_W-1:0] t);
        logic [IDX_W-1:0] base;
        logic [2:0]       j;
        base = '0;
        j    = 3'd0;
        for (int b = 0; b < IDX_W; b++) begin
            if ((STAGE_W'(b) == s) || (STAGE_W'(b) == t)) begin
                base[b] = 1'b0;
            end else begin
                base[b] = c[j];
                j       = j + 3'd1;
            end
        end
        return base;
    endfunction

endpackage

// File: rtl/ntt_addr_gen_bank_map.sv
// Coefficient index to (bank, address): bank is the base-4 digit sum mod 4,
// which spreads every butterfly quartet over all four banks.
module ntt_addr_gen_bank_map
    import ntt_addr_gen_pkg::*;
(
    input  logic [IDX_W-1:0]  index,
    output logic [BANK_W-1:0] bank,
    output logic [ADDR_W-1:0] addr
);

    logic [IDX_W:0]      padded_s;
    logic [BANK_W-1:0]   sum_s;

    // Digit-sum of the zero-extended index, wrapping naturally at 2 bits
    always_comb begin
        padded_s = {1'b0, index};
        sum_s    = '0;
        for (int d = 0; d < (IDX_W + 1) / 2; d++) begin
            sum_s = sum_s + padded_s[2*d +: 2];
        end
        bank = sum_s;
        addr = index[IDX_W-1:BANK_W];
    end

endmodule

// File: rtl/ntt_addr_gen.sv
// Stage/butterfly address sequencer for a 4-bank in-place 512-point NTT,
// with a matching write-back stream delayed by the butterfly pipeline.
module ntt_addr_gen
    import ntt_addr_gen_pkg::*;
#(
    parameter int PIPE_LAT  = 8,
    parameter int STAGE_GAP = 10
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    output logic               busy,
    output logic               done,
    output logic [STAGE_W-1:0] stage,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  raddr0,
    output logic [ADDR_W-1:0]  raddr1,
    output logic [ADDR_W-1:0]  raddr2,
    output logic [ADDR_W-1:0]  raddr3,
    output logic [SEL_W-1:0]   sel_a_0,
    output logic [SEL_W-1:0]   sel_a_1,
    output logic [SEL_W-1:0]   sel_a_2,
    output logic [SEL_W-1:0]   sel_a_3,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  waddr0,
    output logic [ADDR_W-1:0]  waddr1,
    output logic [ADDR_W-1:0]  waddr2,
    output logic [ADDR_W-1:0]  waddr3,
    output logic [SEL_W-1:0]   sel_w_0,
    output logic [SEL_W-1:0]   sel_w_1,
    output logic [SEL_W-1:0]   sel_w_2,
    output logic [SEL_W-1:0]   sel_w_3
);

    localparam int WAIT_W = 16;
    localparam logic [BANKS-1:0][SEL_W-1:0] ROLE_SEL = {SEL_V1, SEL_U1, SEL_V0, SEL_U0};

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    c_r, c_s;
    logic [STAGE_W-1:0]  s_r, s_s;
    logic [WAIT_W-1:0]   wait_r, wait_s;
    logic                busy_r, done_r;
    logic                issue_s, done_s;

    logic [STAGE_W-1:0]                t_s;
    logic [IDX_W-1:0]                  base_s;
    logic [BANKS-1:0][IDX_W-1:0]       idx_s;
    logic [BANKS-1:0][BANK_W-1:0]      bank_s;
    logic [BANKS-1:0][ADDR_W-1:0]      addr_s;

    bank_req_t rd_req_s, rd_req_r;
    bank_req_t line_r [PIPE_LAT];

    // Butterfly quartet for the current counter: u0, v0, u1, v1
    always_comb begin
        t_s      = partner_bit(s_r);
        base_s   = expand_index(c_r, s_r, t_s);
        idx_s[0] = base_s;
        idx_s[1] = base_s | (IDX_W'(1) << s_r);
        idx_s[2] = base_s | (IDX_W'(1) << t_s);
        idx_s[3] = base_s | (IDX_W'(1) << s_r) | (IDX_W'(1) << t_s);
    end

    for (genvar k = 0; k < BANKS; k++) begin : g_map
        ntt_addr_gen_bank_map u_map (
            .index (idx_s[k]),
            .bank  (bank_s[k]),
            .addr  (addr_s[k])
        );
    end

    // Steer each role to the bank it lands in; banks are distinct by construction
    always_comb begin
        rd_req_s = '0;
        if (issue_s) begin
            rd_req_s.en = 1'b1;
            for (int r = 0; r < BANKS; r++) begin
                rd_req_s.addr[bank_s[r]] = addr_s[r];
                rd_req_s.sel[bank_s[r]]  = ROLE_SEL[r];
            end
        end else begin
            rd_req_s = '0;
        end
    end

    // Sequencer next state; the first read is issued in the start cycle itself
    always_comb begin
        state_s = state_r;
        c_s     = c_r;
        s_s     = s_r;
        wait_s  = wait_r;
        issue_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !done_r) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            RUN: begin
                if (!stall) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            GAP: begin
                if (wait_r == WAIT_W'(STAGE_GAP - 1)) begin
                    state_s = RUN;
                    s_s     = s_r + 4'd1;
                    wait_s  = '0;
                end else begin
                    wait_s  = wait_r + WAIT_W'(1);
                end
            end
            DRAIN: begin
                if (wait_r == WAIT_W'(PIPE_LAT - 1)) begin
                    state_s = IDLE;
                    s_s     = '0;
                    wait_s  = '0;
                    done_s  = 1'b1;
                end else begin
                    wait_s  = wait_r + WAIT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (issue_s) begin
            if (c_r == CNT_LAST) begin
                c_s    = '0;
                wait_s = '0;
                if (s_r == LAST_STAGE) begin
                    state_s = DRAIN;
                end else begin
                    state_s = GAP;
                end
            end else begin
                c_s     = c_r + 7'd1;
                state_s = RUN;
            end
        end else begin
            c_s = c_r;
        end
    end

    // Sequencer state plus registered read-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            c_r      <= '0;
            s_r      <= '0;
            wait_r   <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            rd_req_r <= '0;
        end else begin
            state_r  <= state_s;
            c_r      <= c_s;
            s_r      <= s_s;
            wait_r   <= wait_s;
            busy_r   <= (state_s != IDLE) || done_s;
            done_r   <= done_s;
            rd_req_r <= rd_req_s;
        end
    end

    // Write-back delay line: shifts every cycle, stalls appear as bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                line_r[i] <= '0;
            end
        end else begin
            line_r[0] <= rd_req_r;
            for (int i = 1; i < PIPE_LAT; i++) begin
                line_r[i] <= line_r[i-1];
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign stage   = s_r;
    assign rd_en   = rd_req_r.en;
    assign raddr0  = rd_req_r.addr[0];
    assign raddr1  = rd_req_r.addr[1];
    assign raddr2  = rd_req_r.addr[2];
    assign raddr3  = rd_req_r.addr[3];
    assign sel_a_0 = rd_req_r.sel[0];
    assign sel_a_1 = rd_req_r.sel[1];
    assign sel_a_2 = rd_req_r.sel[2];
    assign sel_a_3 = rd_req_r.sel[3];

    assign wr_en   = line_r[PIPE_LAT-1].en;
    assign waddr0  = line_r[PIPE_LAT-1].addr[0];
    assign waddr1  = line_r[PIPE_LAT-1].addr[1];
    assign waddr2  = line_r[PIPE_LAT-1].addr[2];
    assign waddr3  = line_r[PIPE_LAT-1].addr[3];
    assign sel_w_0 = line_r[PIPE_LAT-1].sel[0];
    assign sel_w_1 = line_r[PIPE_LAT-1].sel[1];
    assign sel_w_2 = line_r[PIPE_LAT-1].sel[2];
    assign sel_w_3 = line_r[PIPE_LAT-1].sel[3];

endmodule

// File: doc/ntt_addr_gen.md
NTT_ADDR_GEN -- requirements
Module: ntt_addr_gen

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 8: cycles from bank read address to write-back of the butterfly result.
REQ-002 SHALL have parameter STAGE_GAP, default 10: idle cycles between stages; legal only if STAGE_GAP >= PIPE_LAT+1.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse; launches a 512-point transform.
REQ-006 SHALL have port stall  in  1  holds read issue while high.
REQ-007 SHALL have port busy  out  1  high from the cycle after accepted start until done.
REQ-008 SHALL have port done  out  1  one-cycle pulse at completion.
REQ-009 SHALL have port stage  out  4  current stage s, 0..8.
REQ-010 SHALL have port rd_en  out  1  read addresses valid this cycle.
REQ-011 SHALL have ports raddr0..raddr3  out  7 each  read address of bank 0..3.
REQ-012 SHALL have ports sel_a_0..sel_a_3  out  2 each  bank k data destination: 00 u0, 01 v0, 10 u1, 11 v1.
REQ-013 SHALL have ports wr_en, waddr0..waddr3 (7), sel_w_0..sel_w_3 (2)  out  rd_en/raddr/sel_a delayed exactly PIPE_LAT cycles.

Function
REQ-014 Mapping: coefficient index i (9 bits) SHALL reside in bank (sum of 2-bit digits of {1'b0,i}) mod 4, at address i>>2.
REQ-015 Per stage s, partner bit t SHALL be s^1 for s<8 and 7 for s=8.
REQ-016 7-bit cycle counter c SHALL expand to base index by inserting zeros at bit positions s and t, c bits filling remaining positions LSB-first.
REQ-017 Each read cycle SHALL address u0=base, v0=base+2^s, u1=base+2^t, v1=base+2^s+2^t; all four SHALL map to distinct banks.
REQ-018 raddrK/sel_a_K SHALL be registered outputs, mutually aligned, for the index landing in bank K; the downstream routing network applies the RAM read-latency delay.
REQ-019 FSM states: IDLE, RUN, GAP, DRAIN. IDLE->RUN on start (c=0, s=0); RUN issues one read per non-stalled cycle; after c=127 -> GAP if s<8, else DRAIN.
REQ-020 GAP SHALL last exactly STAGE_GAP cycles with rd_en=0, then s increments, c=0, -> RUN.
REQ-021 DRAIN SHALL last PIPE_LAT cycles; done pulses in the cycle the last wr_en is high; next cycle -> IDLE, busy=0.
REQ-022 stall=1 in RUN SHALL force rd_en=0 and hold c and s; stall is ignored in IDLE/GAP/DRAIN.
REQ-023 start while busy SHALL be ignored; start coincident with done SHALL be ignored.
REQ-024 Write delay line SHALL shift every cycle regardless of stall; bubbles carry wr_en=0.
REQ-025 Unstalled run time: 9*128 + 8*STAGE_GAP + PIPE_LAT cycles from start to done inclusive of read cycles.

Reset
REQ-026 rst SHALL return FSM to IDLE mid-operation, clear c, s, delay line; busy, done, rd_en, wr_en, all addresses and selects = 0 the cycle after.
REQ-027 rst SHALL dominate start in the same cycle.

Structure
REQ-028 Shared package SHALL hold N=512, BANKS=4, ADDR_W=7, SEL_W=2, FSM state typedef, and the sel encoding constants.
REQ-029 One sub-module SHALL be natural: bank_map (combinational index -> bank, address), instantiated four times.
REQ-030 Delay line SHALL be a parameterized register chain of depth PIPE_LAT.

Verification
REQ-031 Stage 0, c=0 -> indices 0,1,2,3; raddr0..3=0; sel_a_0..3 = 00,01,10,11.
REQ-032 Stage 2, c=1 -> indices 1,5,9,13; bank1 addr0 sel00, bank2 addr1 sel01, bank3 addr2 sel10, bank0 addr3 sel11.
REQ-033 Stage 8, c=0 -> indices 0,256,128,384; raddr0..3=0,64,32,96; sel_a_0..3 = 00,01,10,11.
REQ-034 Full run, defaults, no stall -> done at cycle 1152+80+8 after start; every index read exactly once per stage; wr_en count 1152.
REQ-035 stall high 5 cycles at c=40 stage 3 -> c holds 40, rd_en low 5 cycles, wr_en gap of 5 appears PIPE_LAT later, done delayed 5.
REQ-036 rst at stage 4 c=60 -> all outputs 0 next cycle, IDLE; subsequent start completes normally.
